// File: rtl/bsnn_stack_tmux.sv
// bsnn_stack_tmux: time-multiplexed binary SNN layer stack.
// One shared XNOR-popcount engine evaluates LANES neurons per cycle and walks through up to
// NUM_LAYERS square WIDTHxWIDTH layers whose weights and thresholds live in local registers.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_in_valid/o_in_ready   input row handshake (ready only while idle)
//   i_in_row                binary input activations
//   i_cfg_layers            layers to run, sampled on accept (0 -> 1, clamped to NUM_LAYERS)
//   o_out_valid/i_out_ready result handshake (valid while a result is held)
//   o_out_spikes            final-layer spike vector
//   i_w_we/i_w_addr/i_w_data            weight row write, address = layer*WIDTH + neuron
//   i_thr_we/i_thr_layer/i_thr_data     per-layer threshold write
//   o_cfg_err               1-cycle pulse after a rejected write (busy or out of range)
//
// i_w_addr and i_thr_layer carry one spare code point so an out-of-range target is
// expressible (and rejected) even when the storage size is a power of two.
module bsnn_stack_tmux #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LANES      = 8,
  parameter int unsigned NUM_LAYERS = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_in_valid,
  output logic                                  o_in_ready,
  input  logic [WIDTH-1:0]                      i_in_row,
  input  logic [$clog2(NUM_LAYERS+1)-1:0]       i_cfg_layers,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic [WIDTH-1:0]                      o_out_spikes,
  input  logic                                  i_w_we,
  input  logic [$clog2(NUM_LAYERS*WIDTH+1)-1:0] i_w_addr,
  input  logic [WIDTH-1:0]                      i_w_data,
  input  logic                                  i_thr_we,
  input  logic [$clog2(NUM_LAYERS+1)-1:0]       i_thr_layer,
  input  logic [$clog2(WIDTH+1)-1:0]            i_thr_data,
  output logic                                  o_cfg_err
);

  localparam int unsigned Groups  = WIDTH / LANES;
  localparam int unsigned Rows    = NUM_LAYERS * WIDTH;
  localparam int unsigned CfgW    = $clog2(NUM_LAYERS + 1);
  localparam int unsigned AddrW   = $clog2(Rows + 1);
  localparam int unsigned RowW    = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned LayIdxW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CntW    = $clog2(WIDTH + 1);
  localparam int unsigned GrpW    = (Groups > 1) ? $clog2(Groups) : 1;

  if ((WIDTH % LANES) != 0) begin : g_lanes_chk
    $error("bsnn_stack_tmux: WIDTH must be a multiple of LANES");
  end
  if (NUM_LAYERS < 1) begin : g_layers_chk
    $error("bsnn_stack_tmux: NUM_LAYERS must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [WIDTH-1:0]  r_w   [Rows];
  logic [CntW-1:0]   r_thr [NUM_LAYERS];
  logic [WIDTH-1:0]  r_act;
  logic [WIDTH-1:0]  r_nxt;
  logic [WIDTH-1:0]  r_out_spikes;
  logic [CfgW-1:0]   r_layer;
  logic [CfgW-1:0]   r_nl;
  logic [GrpW-1:0]   r_grp;
  logic              r_cfg_err;

  logic              w_accept;
  logic              w_last_grp;
  logic              w_last_layer;
  logic              w_w_ok;
  logic              w_thr_ok;
  logic              w_err;
  logic [CfgW-1:0]   w_nl_cfg;
  logic [RowW-1:0]   w_row_base;
  logic [LANES-1:0]  w_grp_spk;
  logic [WIDTH-1:0]  w_done_vec;

  function automatic logic [CntW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      c = c + CntW'(v[i]);
    end
    return c;
  endfunction

  assign o_in_ready   = (r_state == StIdle);
  assign o_out_valid  = (r_state == StDone);
  assign o_out_spikes = r_out_spikes;
  assign o_cfg_err    = r_cfg_err;

  assign w_accept     = i_in_valid && (r_state == StIdle);
  assign w_last_grp   = (r_grp == GrpW'(Groups - 1));
  assign w_last_layer = (r_layer == (r_nl - CfgW'(1)));

  // Writes only land while idle and in range; anything else raises the error pulse.
  assign w_w_ok   = (r_state == StIdle) && (i_w_addr < AddrW'(Rows));
  assign w_thr_ok = (r_state == StIdle) && (i_thr_layer < CfgW'(NUM_LAYERS));
  assign w_err    = (i_w_we && !w_w_ok) || (i_thr_we && !w_thr_ok);

  always_comb begin
    w_nl_cfg = i_cfg_layers;
    if (i_cfg_layers == '0) begin
      w_nl_cfg = CfgW'(1);
    end else if (i_cfg_layers > CfgW'(NUM_LAYERS)) begin
      w_nl_cfg = CfgW'(NUM_LAYERS);
    end
  end

  // Shared engine: LANES neurons of the current group of the current layer.
  always_comb begin
    w_row_base = RowW'(int'(r_layer) * int'(WIDTH) + int'(r_grp) * int'(LANES));
    w_grp_spk  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_grp_spk[k] = popcnt(~(r_act ^ r_w[w_row_base + RowW'(k)]))
                     >= r_thr[r_layer[LayIdxW-1:0]];
    end
    w_done_vec = r_nxt;
    w_done_vec[int'(r_grp) * int'(LANES) +: LANES] = w_grp_spk;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_accept) w_state_next = StCompute;
      StCompute: if (w_last_grp && w_last_layer) w_state_next = StDone;
      StDone:    if (i_out_ready) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Rows); i++) begin
        r_w[i] <= '0;
      end
      for (int l = 0; l < int'(NUM_LAYERS); l++) begin
        r_thr[l] <= CntW'(WIDTH / 2);
      end
      r_act        <= '0;
      r_nxt        <= '0;
      r_out_spikes <= '0;
      r_layer      <= '0;
      r_nl         <= CfgW'(1);
      r_grp        <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= w_err;
      if (i_w_we && w_w_ok) begin
        r_w[i_w_addr[RowW-1:0]] <= i_w_data;
      end
      if (i_thr_we && w_thr_ok) begin
        r_thr[i_thr_layer[LayIdxW-1:0]] <= i_thr_data;
      end

      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_act   <= i_in_row;
            r_layer <= '0;
            r_grp   <= '0;
            r_nl    <= w_nl_cfg;
          end
        end
        StCompute: begin
          r_nxt[int'(r_grp) * int'(LANES) +: LANES] <= w_grp_spk;
          if (w_last_grp) begin
            // Completed layer output becomes the next layer's activation.
            r_act   <= w_done_vec;
            r_grp   <= '0;
            r_layer <= r_layer + CfgW'(1);
            if (w_last_layer) begin
              r_out_spikes <= w_done_vec;
            end
          end else begin
            r_grp <= r_grp + GrpW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsnn_stack_tmux.sv
// Bench for bsnn_stack_tmux at WIDTH=8, LANES=2, NUM_LAYERS=2 (4 cycles per layer).
// A transaction-level model tracks weights/thresholds and the expected handshake timing;
// a compare process checks every cycle, and directed scenarios pin literal results.
module tb_bsnn_stack_tmux;

  localparam int W  = 8;
  localparam int LN = 2;
  localparam int NL = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_row;
  logic [1:0] cfg_layers;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_spikes;
  logic       w_we;
  logic [4:0] w_addr;
  logic [7:0] w_data;
  logic       thr_we;
  logic [1:0] thr_layer;
  logic [3:0] thr_data;
  logic       cfg_err;

  int checks   = 0;
  int failures = 0;

  bsnn_stack_tmux #(.WIDTH(W), .LANES(LN), .NUM_LAYERS(NL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_row    (in_row),
    .i_cfg_layers(cfg_layers),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_spikes(out_spikes),
    .i_w_we      (w_we),
    .i_w_addr    (w_addr),
    .i_w_data    (w_data),
    .i_thr_we    (thr_we),
    .i_thr_layer (thr_layer),
    .i_thr_data  (thr_data),
    .o_cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_w [16];
  logic [3:0] m_thr [2];
  int         m_phase;    // 0 idle, 1 busy, 2 done
  int         m_count;
  logic [7:0] m_result;
  logic [7:0] m_out;
  logic       m_err;

  function automatic logic [7:0] model_run(input logic [7:0] row, input int layers);
    logic [7:0] act, nxt;
    act = row;
    for (int l = 0; l < layers; l++) begin
      for (int n = 0; n < W; n++) begin
        nxt[n] = ($countones(~(act ^ m_w[l*W+n])) >= int'(m_thr[l]));
      end
      act = nxt;
    end
    return act;
  endfunction

  function automatic int clamp_layers(input logic [1:0] c);
    if (c == 0) return 1;
    if (int'(c) > NL) return NL;
    return int'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_w[i] = 8'h00;
    m_thr[0] = 4'd4;
    m_thr[1] = 4'd4;
    m_phase  = 0;
    m_count  = 0;
    m_result = 8'h00;
    m_out    = 8'h00;
    m_err    = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_err = (w_we && (m_phase != 0 || w_addr >= 16)) ||
                (thr_we && (m_phase != 0 || thr_layer >= 2));
        case (m_phase)
          0: begin
            if (w_we && w_addr < 16) m_w[w_addr] = w_data;
            if (thr_we && thr_layer < 2) m_thr[thr_layer] = thr_data;
            if (in_valid) begin
              m_count  = clamp_layers(cfg_layers) * (W / LN);
              m_result = model_run(in_row, clamp_layers(cfg_layers));
              m_phase  = 1;
            end
          end
          1: begin
            m_count--;
            if (m_count == 0) begin
              m_out   = m_result;
              m_phase = 2;
            end
          end
          default: if (out_ready) m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_in_ready", 32'(in_ready), 32'(m_phase == 0));
        chk("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
        chk("cyc_out_spikes", 32'(out_spikes), 32'(m_out));
        chk("cyc_cfg_err", 32'(cfg_err), 32'(m_err));
      end
    end
  end

  // ---------------- drivers (all called at posedge+2) ----------------
  task automatic wr_w(input int addr, input logic [7:0] d);
    w_addr = 5'(addr);
    w_data = d;
    w_we   = 1'b1;
    @(posedge clk); #2;
    w_we   = 1'b0;
  endtask

  task automatic wr_thr(input int layer, input int t);
    thr_layer = 2'(layer);
    thr_data  = 4'(t);
    thr_we    = 1'b1;
    @(posedge clk); #2;
    thr_we    = 1'b0;
  endtask

  task automatic start(input logic [7:0] row, input logic [1:0] cfg);
    in_row     = row;
    cfg_layers = cfg;
    in_valid   = 1'b1;
    @(posedge clk); #2;
    in_valid   = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input string name, input logic [7:0] row, input logic [1:0] cfg,
                          input int exp_lat, input logic [7:0] exp_spk);
    int lat;
    start(row, cfg);
    wait_valid(lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_spk"}, 32'(out_spikes), 32'(exp_spk));
    take();
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; in_valid = 0; in_row = 0; cfg_layers = 0; out_ready = 0;
    w_we = 0; w_addr = 0; w_data = 0; thr_we = 0; thr_layer = 0; thr_data = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_spikes", 32'(out_spikes), 32'h00);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // All weights FF, threshold 8: every neuron sees 8 matches.
    for (int i = 0; i < 16; i++) wr_w(i, 8'hFF);
    wr_thr(0, 8);
    wr_thr(1, 8);
    run_case("allff", 8'hFF, 2'd2, 8, 8'hFF);

    // Layer 0 rows AA, single layer.
    for (int i = 0; i < 8; i++) wr_w(i, 8'hAA);
    run_case("aa_match", 8'hAA, 2'd1, 4, 8'hFF);
    run_case("aa_inv", 8'h55, 2'd1, 4, 8'h00);

    // Layer count clamping.
    run_case("cfg0", 8'hAA, 2'd0, 4, 8'hFF);
    run_case("cfg3", 8'h55, 2'd3, 8, 8'h00);

    // Backpressure in DONE.
    start(8'hAA, 2'd1);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (i % 5 == 0) begin
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_spk", 32'(out_spikes), 32'hFF);
        chk("bp_ready", 32'(in_ready), 32'd0);
      end
    end
    take();
    chk("bp_idle_next", 32'(in_ready), 32'd1);
    chk("bp_valid_low", 32'(out_valid), 32'd0);
    run_case("bp_second", 8'h55, 2'd1, 4, 8'h00);

    // Write while busy is dropped.
    start(8'hAA, 2'd1);
    wr_w(0, 8'h55);
    chk("busy_err", 32'(cfg_err), 32'd1);
    wait_valid(lat);
    chk("busy_spk", 32'(out_spikes), 32'hFF);
    take();
    wr_w(16, 8'h55);
    chk("oor_addr_err", 32'(cfg_err), 32'd1);
    wr_thr(2, 0);
    chk("oor_thr_err", 32'(cfg_err), 32'd1);
    run_case("w_unchanged", 8'hAA, 2'd1, 4, 8'hFF);
    wr_thr(0, 0);
    chk("ok_thr_noerr", 32'(cfg_err), 32'd0);
    run_case("thr0_a", 8'h55, 2'd1, 4, 8'hFF);
    run_case("thr0_b", 8'h00, 2'd1, 4, 8'hFF);

    // Threshold above WIDTH: never spikes.
    wr_thr(0, 9);
    run_case("thr9", 8'hAA, 2'd1, 4, 8'h00);

    // Write coincident with accept takes effect for that row.
    wr_thr(0, 8);
    thr_layer = 2'd0; thr_data = 4'd0; thr_we = 1'b1;
    start(8'h55, 2'd1);
    thr_we = 1'b0;
    wait_valid(lat);
    chk("coinc_spk", 32'(out_spikes), 32'hFF);
    take();

    // Asynchronous reset mid-result.
    start(8'hAA, 2'd1);
    wait_valid(lat);
    chk("pre_rst_spk", 32'(out_spikes), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_spk", 32'(out_spikes), 32'h00);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    // Weights now zero and thresholds back to 4: XNOR with 0 gives ~row.
    run_case("post_rst_0f", 8'h0F, 2'd1, 4, 8'hFF);
    run_case("post_rst_07", 8'h07, 2'd1, 4, 8'hFF);
    run_case("post_rst_fe", 8'hFE, 2'd1, 4, 8'h00);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
